// File: rtl/apb_periph_demux_pkg.sv
// Shared types and helpers for the APB peripheral demultiplexer.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, default timeout read data, index-width helper.
package apb_periph_demux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Read data handed back upstream when a slave is aborted by the watchdog.
  localparam logic [31:0] DEF_TIMEOUT_RDATA = 32'hDEAD_BEEF;

  // Width of a slave index: max(1, clog2(n)).
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Address decoder: maps an APB address onto one of N_SLV uniform windows.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows paddr_i continuously.
//
// Ports:
//   paddr_i  in   APB_AW  absolute address
//   idx_o    out  IDXW    window index (meaningful only when hit_o=1)
//   hit_o    out  1       address falls inside one of the N_SLV windows
module apb_addr_decoder
  import apb_periph_demux_pkg::*;
#(
  parameter int                N_SLV        = 3,
  parameter int                APB_AW       = 32,
  parameter logic [APB_AW-1:0] BASE_ADDR    = 32'h0004_0000,
  parameter logic [APB_AW-1:0] REGION_BYTES = 32'h0000_1000,
  parameter int                IDXW         = idx_width(N_SLV)
) (
  input  logic [APB_AW-1:0] paddr_i,
  output logic [IDXW-1:0]   idx_o,
  output logic              hit_o
);

  // REGION_BYTES is a power of two, so the divide is a plain shift.
  localparam int RSH = $clog2(REGION_BYTES);

  logic [APB_AW-1:0] off;
  logic [APB_AW-1:0] idx_full;

  assign off      = paddr_i - BASE_ADDR;
  assign idx_full = off >> RSH;

  // The lower-bound test rejects addresses whose subtraction wrapped.
  assign hit_o = (paddr_i >= BASE_ADDR) && (idx_full < APB_AW'(N_SLV));
  assign idx_o = idx_full[IDXW-1:0];

endmodule

// File: rtl/apb_periph_demux.sv
// APB 1-to-N demux with registered downstream request, error on unmapped
// addresses and a per-transfer watchdog. Latency: mapped T+3 plus slave wait
// states, unmapped T+1, timeout T+2+TIMEOUT_CYCLES. Backpressure: one transfer
// in flight; new setups are only accepted in IDLE.
//
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   s_p*                           upstream APB slave port (from the bridge)
//   m_psel[N_SLV]                  one-hot downstream select
//   m_penable/pwrite/paddr/...     shared downstream control and payload
//   m_pready/pslverr/prdata        per-slave responses (prdata packed by index)
//   timeout_o, timeout_idx_o       abort pulse and index of the aborted slave
module apb_periph_demux
  import apb_periph_demux_pkg::*;
#(
  parameter int                N_SLV          = 3,
  parameter int                APB_AW         = 32,
  parameter int                APB_DW         = 32,
  parameter logic [APB_AW-1:0] BASE_ADDR      = 32'h0004_0000,
  parameter logic [APB_AW-1:0] REGION_BYTES   = 32'h0000_1000,
  parameter int                TIMEOUT_CYCLES = 256,
  parameter logic [APB_DW-1:0] TIMEOUT_RDATA  = APB_DW'(DEF_TIMEOUT_RDATA),
  parameter int                IDXW           = idx_width(N_SLV)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // upstream
  input  logic                    s_psel,
  input  logic                    s_penable,
  input  logic                    s_pwrite,
  input  logic [APB_AW-1:0]       s_paddr,
  input  logic [APB_DW-1:0]       s_pwdata,
  input  logic [APB_DW/8-1:0]     s_pstrb,
  input  logic [2:0]              s_pprot,
  output logic                    s_pready,
  output logic                    s_pslverr,
  output logic [APB_DW-1:0]       s_prdata,
  // downstream
  output logic [N_SLV-1:0]        m_psel,
  output logic                    m_penable,
  output logic                    m_pwrite,
  output logic [APB_AW-1:0]       m_paddr,
  output logic [APB_DW-1:0]       m_pwdata,
  output logic [APB_DW/8-1:0]     m_pstrb,
  output logic [2:0]              m_pprot,
  input  logic [N_SLV-1:0]        m_pready,
  input  logic [N_SLV-1:0]        m_pslverr,
  input  logic [N_SLV*APB_DW-1:0] m_prdata,
  // watchdog
  output logic                    timeout_o,
  output logic [IDXW-1:0]         timeout_idx_o
);

  localparam int CNTW = $clog2(TIMEOUT_CYCLES);

  state_e              state_q, state_d;
  logic [APB_AW-1:0]   addr_q, addr_d;
  logic [APB_DW-1:0]   wdata_q, wdata_d;
  logic [APB_DW/8-1:0] strb_q, strb_d;
  logic [2:0]          prot_q, prot_d;
  logic                write_q, write_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [APB_DW-1:0]   rdata_q, rdata_d;
  logic                slverr_q, slverr_d;
  logic                timeout_q, timeout_d;
  logic [IDXW-1:0]     tidx_q, tidx_d;

  logic [IDXW-1:0]     dec_idx;
  logic                dec_hit;

  logic                sel_rdy;
  logic                sel_err;
  logic [APB_DW-1:0]   sel_rdata;

  apb_addr_decoder #(
    .N_SLV       (N_SLV),
    .APB_AW      (APB_AW),
    .BASE_ADDR   (BASE_ADDR),
    .REGION_BYTES(REGION_BYTES),
    .IDXW        (IDXW)
  ) u_dec (
    .paddr_i(s_paddr),
    .idx_o  (dec_idx),
    .hit_o  (dec_hit)
  );

  // Response of the latched slave only; all other slaves are ignored.
  always_comb begin
    sel_rdy   = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (idx_q == IDXW'(i)) begin
        sel_rdy   = m_pready[i];
        sel_err   = m_pslverr[i];
        sel_rdata = m_prdata[i*APB_DW +: APB_DW];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    prot_d    = prot_q;
    write_d   = write_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    slverr_d  = slverr_q;
    timeout_d = 1'b0;
    tidx_d    = tidx_q;

    unique case (state_q)
      IDLE: begin
        if (s_psel && !s_penable) begin
          addr_d  = s_paddr;
          wdata_d = s_pwdata;
          strb_d  = s_pstrb;
          prot_d  = s_pprot;
          write_d = s_pwrite;
          idx_d   = dec_idx;
          if (dec_hit) begin
            state_d = SETUP;
          end else begin
            state_d  = RESP;
            slverr_d = 1'b1;
            rdata_d  = '0;
          end
        end
      end

      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end

      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (sel_rdy) begin
          state_d  = RESP;
          slverr_d = sel_err;
          rdata_d  = write_q ? '0 : sel_rdata;
        end else if (cnt_q == CNTW'(TIMEOUT_CYCLES - 1)) begin
          // Watchdog abort: the pulse is registered so it lines up with RESP.
          state_d   = RESP;
          slverr_d  = 1'b1;
          rdata_d   = write_q ? '0 : TIMEOUT_RDATA;
          timeout_d = 1'b1;
          tidx_d    = idx_q;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      prot_q    <= '0;
      write_q   <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      slverr_q  <= 1'b0;
      timeout_q <= 1'b0;
      tidx_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      prot_q    <= prot_d;
      write_q   <= write_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      slverr_q  <= slverr_d;
      timeout_q <= timeout_d;
      tidx_q    <= tidx_d;
    end
  end

  // Select is decoded from the registered state and index, so it never
  // glitches with upstream inputs.
  always_comb begin
    m_psel = '0;
    if (state_q == SETUP || state_q == ACCESS) begin
      for (int i = 0; i < N_SLV; i++) begin
        if (idx_q == IDXW'(i)) begin
          m_psel[i] = 1'b1;
        end
      end
    end
  end

  assign m_penable = (state_q == ACCESS);
  assign m_pwrite  = write_q;
  assign m_paddr   = addr_q;
  assign m_pwdata  = wdata_q;
  assign m_pstrb   = strb_q;
  assign m_pprot   = prot_q;

  assign s_pready  = (state_q == RESP);
  assign s_pslverr = (state_q == RESP) && slverr_q;
  assign s_prdata  = (state_q == RESP) ? rdata_q : '0;

  assign timeout_o     = timeout_q;
  assign timeout_idx_o = tidx_q;

endmodule

// File: tb/tb_apb_periph_demux.sv
module tb_apb_periph_demux;

  localparam int          N    = 3;
  localparam int          TC   = 8;
  localparam logic [31:0] BASE = 32'h0004_0000;
  localparam logic [31:0] REG  = 32'h0000_1000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        s_psel = 1'b0, s_penable = 1'b0, s_pwrite = 1'b0;
  logic [31:0] s_paddr = '0, s_pwdata = '0;
  logic [3:0]  s_pstrb = '0;
  logic [2:0]  s_pprot = '0;
  logic        s_pready, s_pslverr;
  logic [31:0] s_prdata;
  logic [N-1:0] m_psel;
  logic        m_penable, m_pwrite;
  logic [31:0] m_paddr, m_pwdata;
  logic [3:0]  m_pstrb;
  logic [2:0]  m_pprot;
  logic [N-1:0] m_pready = '0, m_pslverr = '0;
  logic [N*32-1:0] m_prdata = '0;
  logic        timeout_o;
  logic [1:0]  timeout_idx_o;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_tidx = '0;

  apb_periph_demux #(
    .N_SLV(N), .APB_AW(32), .APB_DW(32), .BASE_ADDR(BASE), .REGION_BYTES(REG),
    .TIMEOUT_CYCLES(TC), .TIMEOUT_RDATA(32'hDEAD_BEEF)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pstrb(s_pstrb), .s_pprot(s_pprot),
    .s_pready(s_pready), .s_pslverr(s_pslverr), .s_prdata(s_prdata),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb), .m_pprot(m_pprot),
    .m_pready(m_pready), .m_pslverr(m_pslverr), .m_prdata(m_prdata),
    .timeout_o(timeout_o), .timeout_idx_o(timeout_idx_o)
  );

  always #5 clk_i = ~clk_i;

  // Slave stimulus for one cycle: the target slave raises pready once `wait_n`
  // ACCESS cycles have passed (ACCESS starts at T+2); every other slave drives
  // random noise, and slave 0 can be forced to assert pready constantly.
  task automatic drive_slaves(input int c, input bit mapped, input int idx,
                              input int wait_n, input logic [31:0] rd,
                              input logic err, input bit garbage0);
    for (int i = 0; i < N; i++) begin
      if (mapped && i == idx) begin
        m_pready[i]         = (c >= 2 + wait_n);
        m_pslverr[i]        = err;
        m_prdata[i*32 +: 32] = rd;
      end else begin
        m_pready[i]         = (garbage0 && i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        m_pslverr[i]        = 1'($urandom_range(0, 1));
        m_prdata[i*32 +: 32] = $urandom;
      end
    end
  endtask

  // Full transfer with cycle-by-cycle comparison against an address-map model.
  task automatic run_xfer(input string nm, input logic [31:0] addr, input logic wr,
                          input logic [31:0] wd, input logic [3:0] strb,
                          input int wait_n, input logic [31:0] rd,
                          input logic err, input bit garbage0);
    longint a;
    bit mapped, to;
    int idx, lat;
    logic [2:0]  prot;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [N-1:0] onehot, e_psel;

    a = longint'(addr);
    mapped = 1'b0;
    idx = 0;
    if (a >= longint'(BASE) && ((a - longint'(BASE)) / longint'(REG)) < N) begin
      mapped = 1'b1;
      idx = int'((a - longint'(BASE)) / longint'(REG));
    end
    to  = mapped && (wait_n >= TC);
    lat = !mapped ? 1 : (to ? 2 + TC : 3 + wait_n);
    exp_rd  = (!mapped || wr) ? 32'h0 : (to ? 32'hDEAD_BEEF : rd);
    exp_err = !mapped || to || err;
    onehot = '0;
    if (mapped) onehot[idx] = 1'b1;
    prot = 3'($urandom_range(0, 7));

    @(negedge clk_i);
    s_psel = 1'b1; s_penable = 1'b0; s_pwrite = wr;
    s_paddr = addr; s_pwdata = wd; s_pstrb = strb; s_pprot = prot;
    drive_slaves(0, mapped, idx, wait_n, rd, err, garbage0);

    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk_i);
      e_psel = (mapped && c <= lat - 1) ? onehot : '0;
      if (c == lat && to) exp_tidx = 2'(idx);

      checks++;
      if (m_psel !== e_psel) begin
        errors++; $display("FAIL %s c%0d m_psel got %b exp %b", nm, c, m_psel, e_psel);
      end
      checks++;
      if (m_penable !== (mapped && c >= 2 && c <= lat - 1)) begin
        errors++; $display("FAIL %s c%0d m_penable got %b", nm, c, m_penable);
      end
      checks++;
      if (s_pready !== (c == lat)) begin
        errors++; $display("FAIL %s c%0d s_pready got %b exp %b", nm, c, s_pready, c == lat);
      end
      checks++;
      if (s_pslverr !== ((c == lat) && exp_err)) begin
        errors++; $display("FAIL %s c%0d s_pslverr got %b exp %b", nm, c, s_pslverr, (c == lat) && exp_err);
      end
      checks++;
      if (s_prdata !== ((c == lat) ? exp_rd : 32'h0)) begin
        errors++; $display("FAIL %s c%0d s_prdata got %h exp %h", nm, c, s_prdata, (c == lat) ? exp_rd : 32'h0);
      end
      checks++;
      if (timeout_o !== ((c == lat) && to)) begin
        errors++; $display("FAIL %s c%0d timeout_o got %b exp %b", nm, c, timeout_o, (c == lat) && to);
      end
      checks++;
      if (timeout_idx_o !== exp_tidx) begin
        errors++; $display("FAIL %s c%0d timeout_idx_o got %0d exp %0d", nm, c, timeout_idx_o, exp_tidx);
      end
      if (mapped && c == 1) begin
        checks++;
        if (m_paddr !== addr || m_pwrite !== wr || m_pwdata !== wd ||
            m_pstrb !== strb || m_pprot !== prot) begin
          errors++;
          $display("FAIL %s payload got a=%h w=%b d=%h s=%h p=%0d exp a=%h w=%b d=%h s=%h p=%0d",
                   nm, m_paddr, m_pwrite, m_pwdata, m_pstrb, m_pprot, addr, wr, wd, strb, prot);
        end
      end

      s_psel    = (c < lat);
      s_penable = (c < lat);
      drive_slaves(c, mapped, idx, wait_n, rd, err, garbage0);
    end
  endtask

  task automatic check_all_zero(input string nm);
    checks++;
    if (s_pready !== 1'b0 || s_pslverr !== 1'b0 || s_prdata !== 32'h0 ||
        m_psel !== '0 || m_penable !== 1'b0 || m_pwrite !== 1'b0 ||
        m_paddr !== 32'h0 || m_pwdata !== 32'h0 || m_pstrb !== 4'h0 ||
        m_pprot !== 3'h0 || timeout_o !== 1'b0 || timeout_idx_o !== 2'h0) begin
      errors++;
      $display("FAIL %s outputs not zero: rdy=%b err=%b rd=%h sel=%b en=%b wr=%b a=%h d=%h s=%h p=%0d to=%b ti=%0d",
               nm, s_pready, s_pslverr, s_prdata, m_psel, m_penable, m_pwrite,
               m_paddr, m_pwdata, m_pstrb, m_pprot, timeout_o, timeout_idx_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_all_zero("reset");
    rst_i = 1'b0;
    exp_tidx = '0;
  endtask

  task automatic test_read_zero_wait();
    run_xfer("rd_s1", 32'h0004_1004, 1'b0, 32'h0, 4'h0, 0, 32'h1234_5678, 1'b0, 1'b0);
  endtask

  task automatic test_write_wait();
    run_xfer("wr_s2", 32'h0004_2000, 1'b1, 32'hA5A5_0001, 4'hF, 3, 32'hFFFF_FFFF, 1'b0, 1'b0);
  endtask

  task automatic test_unmapped();
    run_xfer("unmap_lo", 32'h0003_FFFC, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0, 1'b0);
    run_xfer("unmap_hi", 32'h0004_3000, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0, 1'b0);
    run_xfer("unmap_wrap", 32'hFFFF_FFFC, 1'b1, 32'h1, 4'h1, 0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    run_xfer("timeout_s0", 32'h0004_0010, 1'b0, 32'h0, 4'h0, 1000, 32'h5555_5555, 1'b0, 1'b0);
    run_xfer("ready_last", 32'h0004_2ffc, 1'b0, 32'h0, 4'h0, TC - 1, 32'h7777_0000, 1'b0, 1'b0);
  endtask

  task automatic test_slverr_garbage();
    run_xfer("err_s1", 32'h0004_1100, 1'b0, 32'h0, 4'h0, 1, 32'hCAFE_0001, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk_i);
    s_psel = 1'b1; s_penable = 1'b0; s_pwrite = 1'b0;
    s_paddr = 32'h0004_2040; s_pwdata = 32'h0; s_pstrb = 4'h0; s_pprot = 3'h0;
    drive_slaves(0, 1'b1, 2, 5, 32'h1111_2222, 1'b0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk_i);
      s_penable = 1'b1;
      drive_slaves(c, 1'b1, 2, 5, 32'h1111_2222, 1'b0, 1'b0);
    end
    checks++;
    if (m_psel !== 3'b100 || m_penable !== 1'b1) begin
      errors++; $display("FAIL rst_mid pre-reset access got sel=%b en=%b exp sel=100 en=1", m_psel, m_penable);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    check_all_zero("rst_mid");
    rst_i = 1'b0;
    s_psel = 1'b0; s_penable = 1'b0;
    exp_tidx = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      checks++;
      if (s_pready !== 1'b0 || m_psel !== '0) begin
        errors++; $display("FAIL rst_mid_quiet c%0d got rdy=%b sel=%b exp 0", c, s_pready, m_psel);
      end
    end
    run_xfer("after_rst_s0", 32'h0004_0008, 1'b0, 32'h0, 4'h0, 0, 32'h0BAD_F00D, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      int win, wt;
      logic [31:0] addr;
      win = $urandom_range(0, 4);
      if (win == 4) addr = BASE - 32'(4 * $urandom_range(1, 64));
      else          addr = BASE + 32'(win) * REG + 32'(4 * $urandom_range(0, 1023));
      wt = ($urandom_range(0, 7) == 0) ? TC + $urandom_range(0, 3) : $urandom_range(0, 3);
      run_xfer("rand", addr, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
               wt, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_unmapped();
    test_timeout();
    test_slverr_garbage();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
